fx_mac_feeder: RTL and testbench
================================

Name: fx_mac_feeder

Overview:
- Upstream stage of the fixed-point MAC.
- Holds K signed weights and collects K signed data samples from a valid/ready stream.
- Emits exactly K consecutive (weight, data) pairs with a valid strobe, then forces an idle gap long enough for the MAC to flush its window before the next burst.
- One burst equals one MAC dot-product; the MAC's win/din/vld_i are driven directly from win_o/din_o/vld_o.

Parameters:
WIDTH, 8, bitwidth of weights and data (two's complement, fixed-point format untouched)
K, 9, pairs per burst (window size)
WK, $clog2(K), index width
GAP, 6, minimum idle cycles after a burst; must be >= 5 (elaboration-time check fails otherwise)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
w_we  in  1  weight write strobe
w_addr  in  WK  weight index 0..K-1
w_data  in  WIDTH  signed weight
w_rdy  out  1  weight writes accepted
d_vld  in  1  input sample valid
d_data  in  WIDTH  signed input sample
d_rdy  out  1  feeder can accept a sample
win_o  out  WIDTH  weight to MAC
din_o  out  WIDTH  data to MAC
vld_o  out  1  pair valid to MAC
burst_done  out  1  one-cycle pulse with the last pair of a burst

Behaviour:
- Clock and reset: single clock clk; rst is synchronous, active-high.
- Reset values: all outputs 0 except d_rdy=1 and w_rdy=1. Weight and data banks cleared to 0. State FILL, counters 0. A reset mid-burst aborts the burst; vld_o is 0 on the following cycle.
- States: FILL -> BURST -> GAP -> FILL.
- FILL:
  - d_rdy=1 and w_rdy=1, both combinational from state.
  - A handshake (d_vld & d_rdy) writes d_data into data[fill_cnt] and increments fill_cnt.
  - The K-th handshake moves the block to BURST on the next edge and clears fill_cnt.
- BURST:
  - Lasts exactly K cycles; rd_cnt runs 0..K-1.
  - Registered outputs: win_o=weight[rd_cnt], din_o=data[rd_cnt], vld_o=1.
  - The first vld_o is high in the cycle after the K-th accept edge; no bubbles.
  - burst_done=1 together with pair K-1.
- GAP:
  - vld_o=0 for exactly GAP cycles; win_o/din_o hold their last values.
  - Then return to FILL.
  - Earliest next vld_o is therefore >= GAP+K cycles after the previous burst's first vld_o.
- Weights:
  - A write lands when w_we & w_rdy. w_addr >= K is ignored.
  - Writes in the same cycle as a data handshake are both honoured.
  - Outside FILL, w_rdy=0 and w_we is ignored; a burst never sees a mixed weight set.
- Data source may stall: d_vld gaps in FILL just pause fill_cnt, with no timeout.
- d_vld while d_rdy=0: sample is not taken; the upstream must hold it.
- No arithmetic is performed; values pass bit-exact, signed.

Optional Feature:
- Macro FX_FEEDER_PINGPONG_EN.
- Defined:
  - Two data banks. The fill side accepts into the inactive bank during BURST and GAP, so d_rdy=1 whenever the inactive bank holds fewer than K samples.
  - At GAP end, if the inactive bank is full, banks swap and BURST starts immediately.
  - Otherwise enter FILL and continue filling that bank.
  - Weights remain writable only in FILL.
- Undefined: single bank; d_rdy=0 in BURST and GAP.

Decomposition:
- Package fx_pkg:
  - default WIDTH/K/GAP constants
  - MAC_FLUSH_MIN=5
  - state enum type (FILL, BURST, GAP)
- Sub-module fx_feeder_bank: K x WIDTH register array with synchronous clear, one write port and one combinational read port. Instantiated once for weights and once (or twice with ping-pong) for data.

Test Plan:
- Reset then idle -> vld_o=0, d_rdy=1, w_rdy=1, win_o=din_o=0.
- Load weights 1..9, stream data 10..18 back-to-back -> vld_o high for 9 cycles starting the cycle after the 9th accept; pairs (1,10)...(9,18); burst_done only with (9,18); then exactly 6 cycles of vld_o=0.
- Stream with d_vld toggling every other cycle -> same burst contents; burst starts after the 9th accept; d_rdy=0 throughout BURST/GAP (macro off).
- w_we in BURST writing addr 0 = -128 -> ignored; w_rdy=0; next burst still uses weight 1.
- Assert rst at burst pair 4 -> next cycle vld_o=0, state FILL; a fresh 9 samples produce a full burst of zero weights.
- With FX_FEEDER_PINGPONG_EN, continuous d_vld -> bursts separated by exactly 6 idle cycles; no sample lost or duplicated over 3 windows.

Source files
------------

// File: rtl/fx_pkg.sv
// Shared constants and state type for the MAC feeder.
package fx_pkg;

    localparam int WIDTH_DEF     = 8;
    localparam int K_DEF         = 9;
    localparam int GAP_DEF       = 6;
    localparam int MAC_FLUSH_MIN = 5;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_BURST = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

endpackage

// File: rtl/fx_feeder_bank.sv
// K x WIDTH register bank: synchronous clear, one write port, async read.
module fx_feeder_bank #(
    parameter int WIDTH = 8,
    parameter int K     = 9,
    parameter int WK    = $clog2(K)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [WK-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [WK-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [K];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < K; i++) mem[i] <= '0;
        end else if (we && int'(waddr) < K) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = (int'(raddr) < K) ? mem[raddr] : '0;

endmodule

// File: rtl/fx_mac_feeder.sv
// Feeds K (weight, data) pairs per burst to the MAC, then idles GAP cycles.
// Optional FX_FEEDER_PINGPONG_EN: double data bank, filling during BURST/GAP.
module fx_mac_feeder
    import fx_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int K     = K_DEF,
    parameter int WK    = $clog2(K),
    parameter int GAP   = GAP_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             w_we,
    input  logic [WK-1:0]    w_addr,
    input  logic [WIDTH-1:0] w_data,
    output logic             w_rdy,
    input  logic             d_vld,
    input  logic [WIDTH-1:0] d_data,
    output logic             d_rdy,
    output logic [WIDTH-1:0] win_o,
    output logic [WIDTH-1:0] din_o,
    output logic             vld_o,
    output logic             burst_done
);

    localparam int GW = $clog2(GAP);

    if (GAP < MAC_FLUSH_MIN) begin : g_gap_chk
        $error("fx_mac_feeder: GAP below MAC flush time");
    end

    state_t          state, state_nx;
    logic [WK-1:0]   fill_cnt, rd_cnt, rd_idx;
    logic [GW-1:0]   gap_cnt;
    logic            full, hs, hs_last, gap_end, start;
    logic [WIDTH-1:0] wt_rd, dt_rd;

    assign hs      = d_vld & d_rdy;
    assign hs_last = hs && fill_cnt == WK'(K - 1);
    assign gap_end = state == ST_GAP && gap_cnt == GW'(GAP - 1);
    assign start   = (state == ST_FILL && hs_last)
                   || (gap_end && (full || hs_last));
    assign rd_idx  = (state == ST_BURST) ? rd_cnt + 1'b1 : '0;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_FILL;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_FILL:  if (start) state_nx = ST_BURST;
            ST_BURST: if (rd_cnt == WK'(K - 1)) state_nx = ST_GAP;
            ST_GAP:   if (gap_end) state_nx = start ? ST_BURST : ST_FILL;
            default:  state_nx = ST_FILL;
        endcase
    end

    always_comb begin
        w_rdy = (state == ST_FILL);
`ifdef FX_FEEDER_PINGPONG_EN
        d_rdy = !full;
`else
        d_rdy = (state == ST_FILL);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fill_cnt <= '0;
            rd_cnt   <= '0;
            gap_cnt  <= '0;
            full     <= 1'b0;
        end else begin
            if (hs) fill_cnt <= hs_last ? '0 : fill_cnt + 1'b1;
            if (start)        full <= 1'b0;
            else if (hs_last) full <= 1'b1;
            rd_cnt  <= (state == ST_BURST && rd_cnt != WK'(K - 1))
                     ? rd_cnt + 1'b1 : '0;
            gap_cnt <= (state == ST_GAP && !gap_end)
                     ? gap_cnt + 1'b1 : '0;
        end
    end

    // pair 0 is loaded on the start edge; a same-edge write to weight 0 bypasses
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_o      <= 1'b0;
            burst_done <= 1'b0;
            win_o      <= '0;
            din_o      <= '0;
        end else begin
            burst_done <= 1'b0;
            if (start) begin
                vld_o      <= 1'b1;
                win_o      <= (w_we && w_rdy && w_addr == '0) ? w_data : wt_rd;
                din_o      <= dt_rd;
                burst_done <= (K == 1);
            end else if (state == ST_BURST && rd_cnt != WK'(K - 1)) begin
                vld_o      <= 1'b1;
                win_o      <= wt_rd;
                din_o      <= dt_rd;
                burst_done <= (rd_cnt == WK'(K - 2));
            end else begin
                vld_o      <= 1'b0;
            end
        end
    end

    fx_feeder_bank #(.WIDTH(WIDTH), .K(K), .WK(WK)) u_wts (
        .clk(clk), .rst(rst), .we(w_we & w_rdy), .waddr(w_addr),
        .wdata(w_data), .raddr(rd_idx), .rdata(wt_rd)
    );

`ifdef FX_FEEDER_PINGPONG_EN
    logic             fill_sel, rd_sel, rd_bank;
    logic [WIDTH-1:0] d0_rd, d1_rd;

    always_ff @(posedge clk) begin
        if (rst) begin
            fill_sel <= 1'b0;
            rd_sel   <= 1'b0;
        end else if (start) begin
            rd_sel   <= fill_sel;
            fill_sel <= ~fill_sel;
        end
    end

    assign rd_bank = (state == ST_BURST) ? rd_sel : fill_sel;
    assign dt_rd   = rd_bank ? d1_rd : d0_rd;

    fx_feeder_bank #(.WIDTH(WIDTH), .K(K), .WK(WK)) u_data0 (
        .clk(clk), .rst(rst), .we(hs & ~fill_sel), .waddr(fill_cnt),
        .wdata(d_data), .raddr(rd_idx), .rdata(d0_rd)
    );
    fx_feeder_bank #(.WIDTH(WIDTH), .K(K), .WK(WK)) u_data1 (
        .clk(clk), .rst(rst), .we(hs & fill_sel), .waddr(fill_cnt),
        .wdata(d_data), .raddr(rd_idx), .rdata(d1_rd)
    );
`else
    fx_feeder_bank #(.WIDTH(WIDTH), .K(K), .WK(WK)) u_data (
        .clk(clk), .rst(rst), .we(hs), .waddr(fill_cnt),
        .wdata(d_data), .raddr(rd_idx), .rdata(dt_rd)
    );
`endif

endmodule

// File: tb/tb_fx_mac_feeder.sv
// Bench for fx_mac_feeder: burst-level reference model plus directed literals.
module tb_fx_mac_feeder;

    localparam int W   = 8;
    localparam int K   = 9;
    localparam int WK  = 4;
    localparam int GAP = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          w_we = 1'b0;
    logic [WK-1:0] w_addr = '0;
    logic [W-1:0]  w_data = '0;
    logic          w_rdy;
    logic          d_vld = 1'b0;
    logic [W-1:0]  d_data = '0;
    logic          d_rdy;
    logic [W-1:0]  win_o, din_o;
    logic          vld_o, burst_done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    fx_mac_feeder #(.WIDTH(W), .K(K), .GAP(GAP)) dut (
        .clk(clk), .rst(rst),
        .w_we(w_we), .w_addr(w_addr), .w_data(w_data), .w_rdy(w_rdy),
        .d_vld(d_vld), .d_data(d_data), .d_rdy(d_rdy),
        .win_o(win_o), .din_o(din_o), .vld_o(vld_o),
        .burst_done(burst_done)
    );

    // reference: queue of accepted samples, a burst snapshot and a countdown
    logic [W-1:0] wts [K];
    logic [W-1:0] bw [K];
    logic [W-1:0] bd [K];
    logic [W-1:0] dq [$];
    int busy = 0;
    int pos = 0;
    logic         e_vld = 0, e_done = 0, e_drdy = 1, e_wrdy = 1;
    logic [W-1:0] e_win = 0, e_din = 0;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            foreach (wts[i]) wts[i] = '0;
            dq.delete();
            busy = 0; pos = 0;
            e_vld = 0; e_done = 0; e_win = 0; e_din = 0;
            e_drdy = 1; e_wrdy = 1;
        end else begin
            if (e_wrdy && w_we && int'(w_addr) < K) wts[w_addr] = w_data;
            if (e_drdy && d_vld) dq.push_back(d_data);
            if (busy > 0) begin busy--; pos++; end
            if (busy == 0 && dq.size() == K) begin
                for (int i = 0; i < K; i++) begin
                    bw[i] = wts[i];
                    bd[i] = dq[i];
                end
                dq.delete();
                busy = K + GAP;
                pos = 0;
            end
            e_vld = (busy > 0 && pos < K);
            if (e_vld) begin e_win = bw[pos]; e_din = bd[pos]; end
            e_done = e_vld && pos == K - 1;
            e_wrdy = (busy == 0);
`ifdef FX_FEEDER_PINGPONG_EN
            e_drdy = (dq.size() < K);
`else
            e_drdy = (busy == 0);
`endif
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if ({vld_o, burst_done, d_rdy, w_rdy, win_o, din_o} !==
                {e_vld, e_done, e_drdy, e_wrdy, e_win, e_din}) begin
                errors++;
                $display("FAIL model cyc %0d got v%b d%b r%b w%b %0d/%0d want v%b d%b r%b w%b %0d/%0d",
                    cyc, vld_o, burst_done, d_rdy, w_rdy, $signed(win_o), $signed(din_o),
                    e_vld, e_done, e_drdy, e_wrdy, $signed(e_win), $signed(e_din));
            end
        end
    end

    int n_done = 0;
    int rises [$];
    logic vld_q = 0;
    always @(negedge clk) begin
        if (chk_en && burst_done) n_done++;
        if (chk_en && vld_o && !vld_q) rises.push_back(cyc);
        vld_q = vld_o;
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // push K samples base..base+K-1; optional weight write with the last one
    task automatic feed(input int base, input bit toggle,
                        input bit lw, input int la, input int lv);
        int n;
        bit took;
        for (int i = 0; i < K; i++) begin
            if (toggle) begin d_vld = 1'b0; tick(1); end
            d_vld  = 1'b1;
            d_data = W'(base + i);
            if (lw && i == K - 1) begin
                w_we = 1'b1; w_addr = WK'(la); w_data = W'(lv);
            end
            n = 0;
            do begin
                took = d_rdy;
                tick(1);
                n++;
            end while (!took && n < 50);
            if (!took) chk("feed_timeout", 0, 1);
            w_we = 1'b0;
        end
        d_vld = 1'b0;
    endtask

    task automatic wait_vld(input string nm);
        int n = 0;
        while (!vld_o && n < 60) begin tick(1); n++; end
        chk(nm, int'(vld_o), 1);
    endtask

    initial begin
        tick(1);
        chk_en = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(1);
        chk("rst_vld", int'(vld_o), 0);
        chk("rst_drdy", int'(d_rdy), 1);
        chk("rst_wrdy", int'(w_rdy), 1);
        chk("rst_win", int'(win_o), 0);
        chk("rst_din", int'(din_o), 0);

        for (int i = 0; i < K; i++) begin
            w_we = 1'b1; w_addr = WK'(i); w_data = W'(i + 1);
            tick(1);
        end
        w_we = 1'b0;

        // back-to-back: burst must be visible right after the 9th accept
        feed(10, 1'b0, 1'b0, 0, 0);
        for (int k = 0; k < K; k++) begin
            chk("b1_vld", int'(vld_o), 1);
            chk("b1_win", int'(win_o), k + 1);
            chk("b1_din", int'(din_o), 10 + k);
            chk("b1_done", int'(burst_done), int'(k == K - 1));
`ifndef FX_FEEDER_PINGPONG_EN
            chk("b1_drdy", int'(d_rdy), 0);
`endif
            tick(1);
        end
        for (int g = 0; g < GAP; g++) begin
            chk("b1_gap", int'(vld_o), 0);
            chk("b1_gap_win", int'(win_o), 9);
            tick(1);
        end
        chk("b1_refill", int'(d_rdy), 1);

        // stalling source, plus out-of-range weight writes
        w_we = 1'b1; w_addr = 4'd9; w_data = 8'h77; tick(1);
        w_addr = 4'd15; tick(1);
        w_we = 1'b0;
        feed(20, 1'b1, 1'b0, 0, 0);
        chk("b2_win0", int'(win_o), 1);
        chk("b2_din0", int'(din_o), 20);
        tick(2);
        w_we = 1'b1; w_addr = 4'd0; w_data = 8'h80;
        tick(1);
        chk("b2_wrdy", int'(w_rdy), 0);
        tick(3);
        w_we = 1'b0;
        tick(K + GAP);

        feed(30, 1'b0, 1'b0, 0, 0);
        chk("b3_win0", int'($signed(win_o)), 1);
        tick(K + GAP);

        // weight 0 written together with the last sample
        feed(40, 1'b0, 1'b1, 0, -7);
        chk("b4_win0", int'($signed(win_o)), -7);
        tick(K + GAP);

        // reset mid-burst
        feed(50, 1'b0, 1'b0, 0, 0);
        tick(4);
        chk("b5_pair4", int'(din_o), 54);
        rst = 1'b1;
        tick(1);
        chk("abort_vld", int'(vld_o), 0);
        chk("abort_drdy", int'(d_rdy), 1);
        rst = 1'b0;
        feed(60, 1'b0, 1'b0, 0, 0);
        for (int k = 0; k < K; k++) begin
            chk("b6_win", int'(win_o), 0);
            chk("b6_din", int'(din_o), 60 + k);
            tick(1);
        end
        tick(GAP + 2);
        chk("done_count", n_done, 5);

`ifdef FX_FEEDER_PINGPONG_EN
        begin
            int v = 100;
            int n = 0;
            bit took;
            rises.delete();
            d_vld = 1'b1;
            while (v < 100 + 3 * K && n < 300) begin
                d_data = W'(v);
                took = d_rdy;
                tick(1);
                if (took) v++;
                n++;
            end
            d_vld = 1'b0;
            tick(K + GAP + 5);
            chk("pp_bursts", rises.size(), 3);
            if (rises.size() == 3) begin
                chk("pp_space1", rises[1] - rises[0], K + GAP);
                chk("pp_space2", rises[2] - rises[1], K + GAP);
            end
            chk("pp_done", n_done, 8);
            chk("pp_last_din", int'(din_o), 100 + 3 * K - 1);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
